transpose_tile_core: RTL

Square-tile transpose engine between the AFU input FIFO and output FIFO inside `afu_user`. It reads N consecutive 512-bit lines (one N×N tile of DATA_WIDTH elements, row-major) from the input FIFO into an internal tile buffer. It then writes N lines to the output FIFO, where output line c holds column c of the tile. The tile count is exported so the AFU can compare it against `ctx_length`.

---
 rtl/transpose_tile_core_pkg.sv | 26 ++
 rtl/transpose_tile_core_if.sv | 31 +++
 rtl/transpose_tile_core_tile_buffer.sv | 37 +++
 rtl/transpose_tile_core.sv | 125 ++++++++++++
 4 files changed

// File: rtl/transpose_tile_core_pkg.sv
`default_nettype none
// ============================================================================
// Package : transpose_tile_core_pkg
// Brief   : Shared widths, FSM state type and lane helper for the tile transposer
// Rev     : 1.0
// ============================================================================
package transpose_tile_core_pkg;

    localparam int LINE_WIDTH_DEF = 512;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int N_DEF          = LINE_WIDTH_DEF / DATA_WIDTH_DEF;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Element k of a line, zero-extended to 32 bits (dw <= 32)
    function automatic logic [31:0] lane_get(input logic [LINE_WIDTH_DEF-1:0] line,
                                             input int k, input int dw);
        return 32'((line >> (k * dw)) &
                   ((LINE_WIDTH_DEF'(1) << dw) - LINE_WIDTH_DEF'(1)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/transpose_tile_core_if.sv
`default_nettype none
// ============================================================================
// Interface : transpose_tile_core_if
// Brief     : Input/output line-FIFO handshake bundle of the tile transposer
// Rev       : 1.0
// ============================================================================
interface transpose_tile_core_if
    import transpose_tile_core_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF
);
    logic [LINE_WIDTH-1:0] input_fifo_dout;
    logic                  input_fifo_empty;
    logic                  input_fifo_re;
    logic [LINE_WIDTH-1:0] output_fifo_din;
    logic                  output_fifo_we;
    logic                  output_fifo_almost_full;

    // FIFO side
    modport master (
        output input_fifo_dout, input_fifo_empty, output_fifo_almost_full,
        input  input_fifo_re, output_fifo_din, output_fifo_we
    );

    // Transpose core side
    modport slave (
        input  input_fifo_dout, input_fifo_empty, output_fifo_almost_full,
        output input_fifo_re, output_fifo_din, output_fifo_we
    );
endinterface
`default_nettype wire

// File: rtl/transpose_tile_core_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module : tile_buffer
// Brief  : N x N element store, row-write port and combinational column read
// Rev    : 1.0
// ============================================================================
module tile_buffer
    import transpose_tile_core_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int LINE_WIDTH = LINE_WIDTH_DEF,
    localparam int N          = LINE_WIDTH / DATA_WIDTH,
    localparam int IW         = $clog2(N)
) (
    input  wire logic                  clk,
    input  wire logic                  i_we,
    input  wire logic [IW-1:0]         i_row,
    input  wire logic [LINE_WIDTH-1:0] i_row_data,
    input  wire logic [IW-1:0]         i_col,
    output logic      [LINE_WIDTH-1:0] o_col_data
);

    logic [LINE_WIDTH-1:0] r_rows [N];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_rows[i_row] <= i_row_data;
        end
    end

    // Lane r of the column line is element i_col of row r
    for (genvar r = 0; r < N; r++) begin : g_col
        assign o_col_data[r*DATA_WIDTH +: DATA_WIDTH] = r_rows[r][i_col*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule
`default_nettype wire

// File: rtl/transpose_tile_core.sv
`default_nettype none
// ============================================================================
// Module : transpose_tile_core
// Brief  : Fills an N x N tile from the input FIFO, drains it column-wise
// Rev    : 1.0
// ============================================================================
module transpose_tile_core
    import transpose_tile_core_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF
) (
    input  wire logic             clk,
    input  wire logic             reset,
    transpose_tile_core_if.slave  fifo,
    output logic [31:0]           tile_count,
    output logic                  busy
);

    localparam int             N      = LINE_WIDTH / DATA_WIDTH;
    localparam int             IW     = $clog2(N);
    localparam int             CW     = IW + 1;
    localparam logic [CW-1:0]  C_N    = CW'(N);
    localparam logic [CW-1:0]  C_LAST = CW'(N - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_rd_issued;
    logic [CW-1:0]         r_wr_row;
    logic [CW-1:0]         r_col;
    logic                  r_rd_pending;
    logic                  r_we;
    logic [LINE_WIDTH-1:0] r_din;
    logic [31:0]           r_tile_count;
    logic [LINE_WIDTH-1:0] w_col_data;
    logic                  w_re;
    logic                  w_last_row;
    logic                  w_col_fire;
    logic                  w_last_col;

    tile_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_tile_buffer (
        .clk        (clk),
        .i_we       (r_rd_pending),
        .i_row      (r_wr_row[IW-1:0]),
        .i_row_data (fifo.input_fifo_dout),
        .i_col      (r_col[IW-1:0]),
        .o_col_data (w_col_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobe is gated by reset so no line is popped and then discarded
    always_comb begin
        w_state_nxt = r_state;
        w_re        = 1'b0;
        w_last_row  = 1'b0;
        w_col_fire  = 1'b0;
        w_last_col  = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_re       = !reset && !fifo.input_fifo_empty && (r_rd_issued < C_N);
                w_last_row = r_rd_pending && (r_wr_row == C_LAST);
                if (w_last_row) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_col_fire = !fifo.output_fifo_almost_full;
                w_last_col = w_col_fire && (r_col == C_LAST);
                if (w_last_col) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_issued  <= '0;
            r_wr_row     <= '0;
            r_col        <= '0;
            r_rd_pending <= 1'b0;
            r_we         <= 1'b0;
            r_din        <= '0;
            r_tile_count <= '0;
        end else begin
            r_rd_pending <= w_re;
            r_we         <= w_col_fire;
            if (w_re) begin
                r_rd_issued <= r_rd_issued + CW'(1);
            end
            if (w_last_row) begin
                r_rd_issued <= '0;
                r_wr_row    <= '0;
            end else if (r_rd_pending) begin
                r_wr_row <= r_wr_row + CW'(1);
            end
            if (w_col_fire) begin
                r_din <= w_col_data;
                r_col <= w_last_col ? '0 : r_col + CW'(1);
            end
            if (w_last_col) begin
                r_tile_count <= r_tile_count + 32'd1;
            end
        end
    end

    assign fifo.input_fifo_re   = w_re;
    assign fifo.output_fifo_we  = r_we;
    assign fifo.output_fifo_din = r_din;
    assign tile_count           = r_tile_count;
    assign busy                 = !((r_state == ST_FILL) && (r_wr_row == '0));

endmodule
`default_nettype wire
